// File: rtl/ft245_duplex_sched.sv
// FT245 parallel-FIFO bus cycle scheduler: arbitrates RD#/WR cycles on one bus.
// Optional FT245_SYNC_EN adds 2-flop synchronisers on rxf_n_i, txe_n_i and d_i.
module ft245_duplex_sched #(
  parameter int RD_CYC    = 4,
  parameter int WR_CYC    = 4,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter int PRE_CYC   = 4,
  parameter int CW        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxf_n_i,
  input  logic       txe_n_i,
  output logic       rd_n_o,
  output logic       wr_o,
  input  logic [7:0] d_i,
  output logic [7:0] d_o,
  output logic       d_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       busy_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_LOW   = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_HIGH  = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;
  localparam logic [2:0] S_RECOVER  = 3'd5;

  logic       w_rxf_n;
  logic       w_txe_n;
  logic [7:0] w_d;

`ifdef FT245_SYNC_EN
  localparam int RD_LEN = RD_CYC + 2;

  logic [1:0] r_rxf_sync;
  logic [1:0] r_txe_sync;
  logic [7:0] r_d_s1;
  logic [7:0] r_d_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxf_sync <= 2'b11;
      r_txe_sync <= 2'b11;
      r_d_s1     <= 8'h00;
      r_d_s2     <= 8'h00;
    end else begin
      r_rxf_sync <= {r_rxf_sync[0], rxf_n_i};
      r_txe_sync <= {r_txe_sync[0], txe_n_i};
      r_d_s1     <= d_i;
      r_d_s2     <= r_d_s1;
    end
  end

  assign w_rxf_n = r_rxf_sync[1];
  assign w_txe_n = r_txe_sync[1];
  assign w_d     = r_d_s2;
`else
  localparam int RD_LEN = RD_CYC;

  assign w_rxf_n = rxf_n_i;
  assign w_txe_n = txe_n_i;
  assign w_d     = d_i;
`endif

  // Counters load N-1 and advance the state when they reach zero.
  localparam logic [CW-1:0] RD_LOAD  = CW'(RD_LEN - 1);
  localparam logic [CW-1:0] SU_LOAD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] WR_LOAD  = CW'(WR_CYC - 1);
  localparam logic [CW-1:0] HD_LOAD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] PRE_LOAD = CW'(PRE_CYC - 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last_wr;

  logic w_rd_ok;
  logic w_wr_ok;
  logic w_cnt_done;
  logic w_pick_rd;

  assign w_rd_ok    = !w_rxf_n && !rx_valid_o;
  assign w_wr_ok    = !w_txe_n && tx_valid_i;
  assign w_cnt_done = (r_cnt == '0);
  assign w_pick_rd  = w_rd_ok && (!w_wr_ok || r_last_wr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_last_wr  <= 1'b1;
      rd_n_o     <= 1'b1;
      wr_o       <= 1'b0;
      d_o        <= 8'h00;
      d_oe_o     <= 1'b0;
      tx_ready_o <= 1'b0;
      rx_data_o  <= 8'h00;
      rx_valid_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      tx_ready_o <= 1'b0;
      if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      if (!w_cnt_done) begin
        r_cnt <= r_cnt - CW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (w_pick_rd) begin
            r_state   <= S_RD_LOW;
            r_cnt     <= RD_LOAD;
            r_last_wr <= 1'b0;
            rd_n_o    <= 1'b0;
            busy_o    <= 1'b1;
          end else if (w_wr_ok) begin
            r_state    <= S_WR_SETUP;
            r_cnt      <= SU_LOAD;
            r_last_wr  <= 1'b1;
            tx_ready_o <= 1'b1;
            d_o        <= tx_data_i;
            d_oe_o     <= 1'b1;
            busy_o     <= 1'b1;
          end
        end
        S_RD_LOW: begin
          if (w_cnt_done) begin
            r_state    <= S_RECOVER;
            r_cnt      <= PRE_LOAD;
            rd_n_o     <= 1'b1;
            rx_data_o  <= w_d;
            rx_valid_o <= 1'b1;
          end
        end
        S_WR_SETUP: begin
          if (w_cnt_done) begin
            r_state <= S_WR_HIGH;
            r_cnt   <= WR_LOAD;
            wr_o    <= 1'b1;
          end
        end
        S_WR_HIGH: begin
          if (w_cnt_done) begin
            r_state <= S_WR_HOLD;
            r_cnt   <= HD_LOAD;
            wr_o    <= 1'b0;
          end
        end
        S_WR_HOLD: begin
          if (w_cnt_done) begin
            r_state <= S_RECOVER;
            r_cnt   <= PRE_LOAD;
            d_oe_o  <= 1'b0;
          end
        end
        S_RECOVER: begin
          if (w_cnt_done) begin
            r_state <= S_IDLE;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          rd_n_o  <= 1'b1;
          wr_o    <= 1'b0;
          d_oe_o  <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
